operand_fetch: RTL and testbench

OPERAND_FETCH -- requirements
Module: operand_fetch

---
 rtl/op_fetch_pkg.sv | 15 +
 rtl/op_scoreboard.sv | 50 +++++
 rtl/operand_fetch.sv | 100 ++++++++++
 tb/tb_operand_fetch.sv | 295 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/op_fetch_pkg.sv
// Shared widths and the registered operand bundle for the operand-fetch stage.
package op_fetch_pkg;

  localparam int XLEN_DEF = 32;
  localparam int NREG_DEF = 32;
  localparam int AW_DEF   = $clog2(NREG_DEF);

  typedef struct packed {
    logic [XLEN_DEF-1:0] rs1_data;
    logic [XLEN_DEF-1:0] rs2_data;
    logic [AW_DEF-1:0]   rd;
    logic                rd_we;
  } op_bundle_t;

endpackage

// File: rtl/op_scoreboard.sv
// Pending-write scoreboard: one bit per architectural register plus a registered population count.
module op_scoreboard
  import op_fetch_pkg::*;
#(
  parameter int NREG = NREG_DEF,
  parameter int AW   = $clog2(NREG)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            set_en,
  input  logic [AW-1:0]   set_idx,
  input  logic            wb_clr_en,
  input  logic [AW-1:0]   wb_clr_idx,
  input  logic            fl_clr_en,
  input  logic [AW-1:0]   fl_clr_idx,
  output logic [NREG-1:0] pending,
  output logic [AW:0]     pending_cnt
);

  logic [NREG-1:0] pend_nxt;
  logic [AW:0]     cnt_nxt;

  always_comb begin
    // NOTE: every always_comb output starts from a full default so no path leaves it unassigned (no latch).
    pend_nxt = pending;
    if (wb_clr_en) pend_nxt[wb_clr_idx] = 1'b0;
    if (fl_clr_en) pend_nxt[fl_clr_idx] = 1'b0;
    // Set is applied last so a same-cycle issue beats a retiring writeback to the same register.
    if (set_en)    pend_nxt[set_idx]    = 1'b1;
    pend_nxt[0] = 1'b0;

    cnt_nxt = '0;
    for (int i = 1; i < NREG; i++) begin
      cnt_nxt = cnt_nxt + {{AW{1'b0}}, pend_nxt[i]};
    end
  end

  // NOTE: the pending array is a handful of flops, not a RAM, so it is safe and required to reset it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pending     <= '0;
      pending_cnt <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignment so all flops update from pre-edge values.
      pending     <= pend_nxt;
      pending_cnt <= cnt_nxt;
    end
  end

endmodule

// File: rtl/operand_fetch.sv
// Operand fetch with scoreboard hazard stall and registered operand bundle.
// Define OPERAND_FETCH_BYPASS_EN to resolve hazards and operands from the same-cycle writeback.
module operand_fetch
  import op_fetch_pkg::*;
#(
  parameter  int XLEN = XLEN_DEF,
  parameter  int NREG = NREG_DEF,
  localparam int AW   = $clog2(NREG)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [AW-1:0]   in_rs1,
  input  logic [AW-1:0]   in_rs2,
  input  logic [AW-1:0]   in_rd,
  input  logic            in_rd_we,
  output logic [AW-1:0]   rf_rs1_addr,
  output logic [AW-1:0]   rf_rs2_addr,
  input  logic [XLEN-1:0] rf_rs1_data,
  input  logic [XLEN-1:0] rf_rs2_data,
  input  logic            wb_valid,
  input  logic [AW-1:0]   wb_rd,
  input  logic [XLEN-1:0] wb_data,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_rs1_data,
  output logic [XLEN-1:0] out_rs2_data,
  output logic [AW-1:0]   out_rd,
  output logic            out_rd_we,
  input  logic            flush,
  output logic [AW:0]     pending_cnt
);

  logic [NREG-1:0] pending;
  logic            rs1_byp, rs2_byp, rd_byp;
  logic            rs1_haz, rs2_haz, rd_haz;
  logic            accept;
  logic [XLEN-1:0] rs1_op, rs2_op;
  op_bundle_t      bundle_q;

  assign rf_rs1_addr = in_rs1;
  assign rf_rs2_addr = in_rs2;

`ifdef OPERAND_FETCH_BYPASS_EN
  assign rs1_byp = wb_valid && (wb_rd == in_rs1);
  assign rs2_byp = wb_valid && (wb_rd == in_rs2);
  assign rd_byp  = wb_valid && (wb_rd == in_rd);
`else
  assign rs1_byp = 1'b0;
  assign rs2_byp = 1'b0;
  assign rd_byp  = 1'b0;
`endif

  assign rs1_haz  = pending[in_rs1] && (in_rs1 != '0) && !rs1_byp;
  assign rs2_haz  = pending[in_rs2] && (in_rs2 != '0) && !rs2_byp;
  assign rd_haz   = in_rd_we && (in_rd != '0) && pending[in_rd] && !rd_byp;
  assign in_ready = (!out_valid || out_ready) && !flush && !(rs1_haz || rs2_haz || rd_haz);
  assign accept   = in_valid && in_ready;

  assign rs1_op = (in_rs1 == '0) ? '0 : (rs1_byp ? wb_data : rf_rs1_data);
  assign rs2_op = (in_rs2 == '0) ? '0 : (rs2_byp ? wb_data : rf_rs2_data);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      bundle_q  <= '0;
    end else if (flush) begin
      out_valid <= 1'b0;
    end else if (accept) begin
      out_valid <= 1'b1;
      bundle_q  <= '{rs1_data: rs1_op, rs2_data: rs2_op, rd: in_rd, rd_we: in_rd_we};
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

  assign out_rs1_data = bundle_q.rs1_data;
  assign out_rs2_data = bundle_q.rs2_data;
  assign out_rd       = bundle_q.rd;
  assign out_rd_we    = bundle_q.rd_we;

  // A flushed bundle never writes back, so its destination must stop looking busy.
  op_scoreboard #(
    .NREG (NREG),
    .AW   (AW)
  ) u_scoreboard (
    .clk         (clk),
    .rst         (rst),
    .set_en      (accept && in_rd_we && (in_rd != '0)),
    .set_idx     (in_rd),
    .wb_clr_en   (wb_valid && (wb_rd != '0)),
    .wb_clr_idx  (wb_rd),
    .fl_clr_en   (flush && out_valid && bundle_q.rd_we),
    .fl_clr_idx  (bundle_q.rd),
    .pending     (pending),
    .pending_cnt (pending_cnt)
  );

endmodule

// File: tb/tb_operand_fetch.sv
// Directed bench for operand_fetch: per-cycle comparison against a behavioural model plus literal checks.
module tb_operand_fetch;

`ifdef OPERAND_FETCH_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_ready;
  logic [4:0]  in_rs1, in_rs2, in_rd;
  logic        in_rd_we;
  logic [4:0]  rf_rs1_addr, rf_rs2_addr;
  logic [31:0] rf_rs1_data, rf_rs2_data;
  logic        wb_valid;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic        out_valid, out_ready;
  logic [31:0] out_rs1_data, out_rs2_data;
  logic [4:0]  out_rd;
  logic        out_rd_we;
  logic        flush;
  logic [5:0]  pending_cnt;

  int n_vec = 0;
  int n_err = 0;
  bit chk_en = 1'b0;

  // Register file emulation and behavioural model state
  logic [31:0] xreg [32];
  bit   [31:0] m_pend;
  logic        m_valid;
  logic [31:0] m_rs1, m_rs2;
  logic [4:0]  m_rd;
  logic        m_we;

  always #5 clk = ~clk;

  assign rf_rs1_data = xreg[rf_rs1_addr];
  assign rf_rs2_data = xreg[rf_rs2_addr];

  operand_fetch dut (
    .clk          (clk),
    .rst          (rst),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_rs1       (in_rs1),
    .in_rs2       (in_rs2),
    .in_rd        (in_rd),
    .in_rd_we     (in_rd_we),
    .rf_rs1_addr  (rf_rs1_addr),
    .rf_rs2_addr  (rf_rs2_addr),
    .rf_rs1_data  (rf_rs1_data),
    .rf_rs2_data  (rf_rs2_data),
    .wb_valid     (wb_valid),
    .wb_rd        (wb_rd),
    .wb_data      (wb_data),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_rs1_data (out_rs1_data),
    .out_rs2_data (out_rs2_data),
    .out_rd       (out_rd),
    .out_rd_we    (out_rd_we),
    .flush        (flush),
    .pending_cnt  (pending_cnt)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit wb_hits(input logic [4:0] r);
    return BYP && wb_valid && (wb_rd == r);
  endfunction

  function automatic bit model_ready();
    bit haz;
    haz = ((in_rs1 != 0) && m_pend[in_rs1] && !wb_hits(in_rs1)) ||
          ((in_rs2 != 0) && m_pend[in_rs2] && !wb_hits(in_rs2)) ||
          (in_rd_we && (in_rd != 0) && m_pend[in_rd] && !wb_hits(in_rd));
    return (!m_valid || out_ready) && !flush && !haz;
  endfunction

  function automatic logic [31:0] operand(input logic [4:0] r);
    if (r == 0)      return 32'h0;
    if (wb_hits(r))  return wb_data;
    return xreg[r];
  endfunction

  always @(posedge clk or posedge rst) begin
    bit          acc;
    bit   [31:0] nxt;
    if (rst) begin
      m_pend  = '0;
      m_valid = 1'b0;
      m_rs1   = '0;
      m_rs2   = '0;
      m_rd    = '0;
      m_we    = 1'b0;
      for (int i = 0; i < 32; i++) xreg[i] <= (i == 0) ? 32'h0 : 32'h1000_0000 | 32'(i);
      xreg[5] <= 32'h11;
      xreg[6] <= 32'h22;
    end else begin
      acc = in_valid && model_ready();
      nxt = m_pend;
      if (wb_valid && wb_rd != 0) nxt[wb_rd] = 1'b0;
      if (flush && m_valid && m_we) nxt[m_rd] = 1'b0;
      if (acc && in_rd_we && in_rd != 0) nxt[in_rd] = 1'b1;
      if (flush) m_valid = 1'b0;
      else if (acc) begin
        m_valid = 1'b1;
        m_rs1   = operand(in_rs1);
        m_rs2   = operand(in_rs2);
        m_rd    = in_rd;
        m_we    = in_rd_we;
      end else if (out_ready) m_valid = 1'b0;
      if (wb_valid && wb_rd != 0) xreg[wb_rd] <= wb_data;
      m_pend = nxt;
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("in_ready", in_ready, model_ready());
      check("out_valid", out_valid, m_valid);
      check("pending_cnt", pending_cnt, $countones(m_pend));
      check("rf_rs1_addr", rf_rs1_addr, in_rs1);
      check("rf_rs2_addr", rf_rs2_addr, in_rs2);
      if (m_valid) begin
        check("out_rs1_data", out_rs1_data, m_rs1);
        check("out_rs2_data", out_rs2_data, m_rs2);
        check("out_rd", out_rd, m_rd);
        check("out_rd_we", out_rd_we, m_we);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    in_valid = 1'b0; in_rs1 = '0; in_rs2 = '0; in_rd = '0; in_rd_we = 1'b0;
    wb_valid = 1'b0; wb_rd = '0; wb_data = '0;
    flush = 1'b0; out_ready = 1'b1;
  endtask

  task automatic issue(input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd, input logic we);
    in_valid = 1'b1; in_rs1 = rs1; in_rs2 = rs2; in_rd = rd; in_rd_we = we;
  endtask

  initial begin
    idle();
    rst = 1'b0;
    #1 rst = 1'b1;
    #1 chk_en = 1'b1;
    tick(); tick();
    check("rst_out_valid", out_valid, 0);
    check("rst_pending_cnt", pending_cnt, 0);
    check("rst_out_rs1", out_rs1_data, 0);
    check("rst_out_rd", out_rd, 0);
    check("rst_out_rd_we", out_rd_we, 0);
    rst = 1'b0;
    #1 check("ready_after_rst", in_ready, 1);

    // Basic accept with latency 1
    issue(5, 6, 7, 1'b1);
    tick(); idle();
    check("acc_valid", out_valid, 1);
    check("acc_rs1", out_rs1_data, 32'h11);
    check("acc_rs2", out_rs2_data, 32'h22);
    check("acc_rd", out_rd, 7);
    check("acc_cnt", pending_cnt, 1);
    tick();
    check("drain_valid", out_valid, 0);

    // RAW hazard on x7 resolved by writeback
    issue(7, 0, 0, 1'b0);
    #1 check("raw_stall", in_ready, 0);
    tick();
    wb_valid = 1'b1; wb_rd = 7; wb_data = 32'hABCD;
`ifdef OPERAND_FETCH_BYPASS_EN
    #1 check("raw_bypass_ready", in_ready, 1);
    tick(); idle();
`else
    #1 check("raw_wb_cycle_ready", in_ready, 0);
    tick();
    wb_valid = 1'b0; wb_rd = '0; wb_data = '0;
    #1 check("raw_next_ready", in_ready, 1);
    tick(); idle();
`endif
    check("raw_valid", out_valid, 1);
    check("raw_rs1", out_rs1_data, 32'hABCD);
    check("raw_cnt", pending_cnt, 0);
    tick();

    // Set beats same-cycle clear on x9, then RAW and WAW stalls against it
    issue(0, 0, 9, 1'b1);
    wb_valid = 1'b1; wb_rd = 9; wb_data = 32'h99;
    tick(); idle();
    check("setwin_cnt", pending_cnt, 1);
    issue(9, 0, 0, 1'b0);
    #1 check("setwin_raw_stall", in_ready, 0);
    issue(0, 0, 9, 1'b1);
    #1 check("waw_stall", in_ready, 0);
    idle();
    wb_valid = 1'b1; wb_rd = 9; wb_data = 32'h77;
    tick(); idle();
    check("x9_clear_cnt", pending_cnt, 0);

    // Back-pressure: held bundle stays stable for three cycles
    out_ready = 1'b0;
    issue(1, 2, 11, 1'b1);
    tick();
    issue(3, 4, 12, 1'b1);
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      check("hold_valid", out_valid, 1);
      check("hold_rs1", out_rs1_data, 32'h1000_0001);
      check("hold_rd", out_rd, 11);
      check("hold_ready", in_ready, 0);
      tick();
    end
    out_ready = 1'b1;
    #1 check("release_ready", in_ready, 1);
    tick(); idle();
    check("release_rd", out_rd, 12);
    check("release_rs1", out_rs1_data, 32'h1000_0003);
    check("release_cnt", pending_cnt, 2);
    wb_valid = 1'b1; wb_rd = 11; wb_data = 32'h5;
    tick();
    wb_rd = 12;
    tick(); idle();
    check("retire_cnt", pending_cnt, 0);

    // Flush a held bundle writing x3
    out_ready = 1'b0;
    issue(0, 0, 3, 1'b1);
    tick();
    issue(0, 0, 4, 1'b1);
    out_ready = 1'b0;
    flush = 1'b1;
    #1 check("flush_ready", in_ready, 0);
    tick(); idle();
    check("flush_valid", out_valid, 0);
    check("flush_cnt", pending_cnt, 0);

    // Reset while stalled with four registers pending
    for (int r = 13; r <= 16; r++) begin
      issue(0, 0, 5'(r), 1'b1);
      tick();
    end
    idle();
    issue(13, 0, 0, 1'b0);
    out_ready = 1'b0;
    #1;
    check("stall_cnt4", pending_cnt, 4);
    check("stall_ready", in_ready, 0);
    tick();
    rst = 1'b1;
    #1;
    check("midrst_valid", out_valid, 0);
    check("midrst_rs1", out_rs1_data, 0);
    check("midrst_rs2", out_rs2_data, 0);
    check("midrst_rd", out_rd, 0);
    check("midrst_rd_we", out_rd_we, 0);
    check("midrst_cnt", pending_cnt, 0);
    tick();
    rst = 1'b0;
    #1 check("post_rst_ready", in_ready, 1);
    tick(); idle();
    check("post_rst_valid", out_valid, 1);
    check("post_rst_rs1", out_rs1_data, 32'h1000_000D);
    tick(); tick();

    chk_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
